// File: rtl/project_mux_ctrl_if.sv
// Wishbone slave bundle between the caravel bus and the IO mux controller.
interface project_mux_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/project_mux_ctrl.sv
// Wishbone-controlled IO mux routing the pads to one of NUM_PROJECTS slots, with a guarded switch sequence.
// Optional: define SWITCH_COUNT_EN to expose a completed-switch counter at STATUS[31:16].
module project_mux_ctrl #(
    parameter int unsigned NUM_PROJECTS = 8,
    parameter int unsigned IO_PADS      = 38,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned RESET_CYCLES = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    project_mux_ctrl_if.slave               wb,
    input  logic [IO_PADS-1:0]              io_in,
    output logic [IO_PADS-1:0]              io_out,
    output logic [IO_PADS-1:0]              io_oeb,
    output logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_in,
    input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out,
    output logic [NUM_PROJECTS-1:0]         proj_reset,
    output logic [3:0]                      active_o
);

    typedef enum logic [1:0] {S_IDLE, S_GUARD, S_RSTP} state_e;

    localparam int unsigned CMAX = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    state_e                                  state_q;
    logic [CW-1:0]                           cnt_q;
    logic [3:0]                              active_q;
    logic [NUM_PROJECTS-1:0]                 prst_q;
    logic [NUM_PROJECTS-1:0][IO_PADS-1:0]    oeb_q;
    logic                                    ack_q, seen_q;
    logic [31:0]                             rdat_q;
    logic                                    busy_err_q, bad_sel_err_q;
    logic [15:0]                             sw_cnt;

    // ---------------- bus decode ----------------
    logic [31:0] offset;
    logic        valid, hit, acc, wr, rd, busy;
    logic [5:0]  wa, oidx;
    logic        oeb_sel, sel_ok, wr_active, wr_status, switch_req, busy_hit, bad_hit;
    logic [3:0]  new_sel;
    logic [31:0] wmask32;
    logic [63:0] wmask64, wdat64;
    logic [IO_PADS-1:0] wmask_p, wdat_p;
    logic        unused_ok;

    assign offset    = wb.wbs_adr_i - BASE_ADDR;
    assign valid     = wb.wbs_cyc_i & wb.wbs_stb_i;
    assign hit       = (offset[31:8] == 24'd0);
    // seen_q blocks a second ack while the same strobe is still held
    assign acc       = valid & hit & ~seen_q;
    assign wr        = acc & wb.wbs_we_i;
    assign rd        = acc & ~wb.wbs_we_i;
    assign wa        = offset[7:2];
    assign oidx      = wa - 6'd4;
    assign oeb_sel   = (wa >= 6'd4) && (oidx[5:1] < 5'(NUM_PROJECTS));
    assign busy      = (state_q != S_IDLE);
    assign new_sel   = wb.wbs_dat_i[3:0];
    assign sel_ok    = ({1'b0, new_sel} < 5'(NUM_PROJECTS));
    assign wr_active = wr & (wa == 6'd0) & wb.wbs_sel_i[0];
    assign wr_status = wr & (wa == 6'd1);
    assign switch_req = wr_active & ~busy & sel_ok & (new_sel != active_q);
    assign busy_hit  = wr_active & busy;
    assign bad_hit   = wr_active & ~busy & ~sel_ok;
    assign unused_ok = ^offset[1:0];

    assign wmask32 = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}},
                      {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};
    assign wmask64 = oidx[0] ? {wmask32, 32'd0} : {32'd0, wmask32};
    assign wdat64  = {wb.wbs_dat_i, wb.wbs_dat_i};
    assign wmask_p = wmask64[IO_PADS-1:0];
    assign wdat_p  = wdat64[IO_PADS-1:0];

    logic [31:0] rdata;
    logic [63:0] oeb_ext;

    always_comb begin
        rdata   = '0;
        oeb_ext = '0;
        for (int p = 0; p < NUM_PROJECTS; p++)
            if (oidx[5:1] == 5'(p)) oeb_ext = 64'(oeb_q[p]);
        case (wa)
            6'd0:    rdata = {23'd0, busy, 4'd0, active_q};
            6'd1:    rdata = {sw_cnt, 14'd0, bad_sel_err_q, busy_err_q};
            default: if (oeb_sel) rdata = oidx[0] ? oeb_ext[63:32] : oeb_ext[31:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q         <= 1'b0;
            seen_q        <= 1'b0;
            rdat_q        <= '0;
            busy_err_q    <= 1'b0;
            bad_sel_err_q <= 1'b0;
            oeb_q         <= '1;
        end else begin
            ack_q         <= acc;
            seen_q        <= valid & (seen_q | acc);
            rdat_q        <= rd ? rdata : 32'd0;
            // a fresh error outranks a clear landing in the same cycle
            busy_err_q    <= (busy_err_q & ~wr_status) | busy_hit;
            bad_sel_err_q <= (bad_sel_err_q & ~wr_status) | bad_hit;
            for (int p = 0; p < NUM_PROJECTS; p++)
                if (wr && oeb_sel && (oidx[5:1] == 5'(p)))
                    oeb_q[p] <= (oeb_q[p] & ~wmask_p) | (wdat_p & wmask_p);
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = rdat_q;

    // ---------------- switch sequencer ----------------
    logic [NUM_PROJECTS-1:0] act_oh;

    always_comb begin
        act_oh = '0;
        for (int p = 0; p < NUM_PROJECTS; p++) act_oh[p] = (active_q == 4'(p));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            active_q <= 4'd0;
            prst_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (switch_req) begin
                    state_q  <= S_GUARD;
                    cnt_q    <= CW'(GUARD_CYCLES - 1);
                    active_q <= new_sel;
                end
                S_GUARD: if (cnt_q == '0) begin
                    state_q <= S_RSTP;
                    cnt_q   <= CW'(RESET_CYCLES - 1);
                    prst_q  <= act_oh;
                end else cnt_q <= cnt_q - 1'b1;
                S_RSTP: if (cnt_q == '0) begin
                    state_q <= S_IDLE;
                    prst_q  <= '0;
                end else cnt_q <= cnt_q - 1'b1;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SWITCH_COUNT_EN
    logic [15:0] sw_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) sw_cnt_q <= '0;
        else if (state_q == S_RSTP && cnt_q == '0) sw_cnt_q <= sw_cnt_q + 16'd1;
    end
    assign sw_cnt = sw_cnt_q;
`else
    assign sw_cnt = '0;
`endif

    // ---------------- pad routing ----------------
    always_comb begin
        io_out     = '0;
        io_oeb     = '1;
        proj_io_in = '0;
        for (int p = 0; p < NUM_PROJECTS; p++) begin
            if (act_oh[p]) begin
                if (state_q == S_IDLE) begin
                    io_out = proj_io_out[p*IO_PADS +: IO_PADS];
                    io_oeb = oeb_q[p];
                end
                // the slot under reset already sees the pads; guard isolates everyone
                if (state_q != S_GUARD) proj_io_in[p*IO_PADS +: IO_PADS] = io_in;
            end
        end
    end

    assign proj_reset = prst_q | {NUM_PROJECTS{reset}};
    assign active_o   = active_q;

endmodule

// File: tb/tb_project_mux_ctrl.sv
// Directed bench for project_mux_ctrl: register table plus switch, busy, held-strobe and reset sequences.
module tb_project_mux_ctrl;
    localparam int N   = 8;
    localparam int IOP = 38;
    localparam int G   = 4;
    localparam int R   = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    project_mux_ctrl_if wb();
    logic [IOP-1:0]   io_in, io_out, io_oeb;
    logic [N*IOP-1:0] proj_io_in, proj_io_out;
    logic [N-1:0]     proj_reset;
    logic [3:0]       active_o;

    project_mux_ctrl #(.NUM_PROJECTS(N), .IO_PADS(IOP), .BASE_ADDR(BASE),
                       .GUARD_CYCLES(G), .RESET_CYCLES(R)) dut (
        .clk(clk), .reset(reset), .wb(wb),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
        .proj_io_in(proj_io_in), .proj_io_out(proj_io_out),
        .proj_reset(proj_reset), .active_o(active_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [IOP-1:0] pat(input int p);
        logic [63:0] t;
        t = 64'hC3A5_1E2D_9B47_6F08 ^ (64'(p) * 64'h0011_2233_4455_6677);
        return t[IOP-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one bus transfer, bounded wait for ack, then one idle cycle
    task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdat, output bit acked);
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
        acked = 1'b0; rdat = '0;
        for (int i = 0; i < 8 && !acked; i++) begin
            tick();
            if (wb.wbs_ack_o) begin acked = 1'b1; rdat = wb.wbs_dat_o; end
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        tick();
    endtask

    task automatic wr(input string nm, input logic [7:0] off, input logic [31:0] dat);
        logic [31:0] r; bit a;
        xfer(1'b1, BASE + 32'(off), dat, 4'hF, r, a);
        chk({nm, "_ack"}, 64'(a), 64'd1);
    endtask

    task automatic rd(input string nm, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] r; bit a;
        xfer(1'b0, BASE + 32'(off), 32'd0, 4'hF, r, a);
        chk({nm, "_ack"}, 64'(a), 64'd1);
        chk(nm, 64'(r), 64'(exp));
    endtask

    task automatic wait_idle();
        repeat (G + R + 2) tick();
    endtask

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        bit          exp_ack;
        string       nm;
    } vec_t;

    vec_t vt[18];

    initial begin
        logic [31:0]      r;
        bit               a;
        logic [N*IOP-1:0] exp_pin;
        int               n_ack, bad_dat, any_rst;

        vt[0]  = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 32'h0000_0000, 1'b1, "rd_active_rst"};
        vt[1]  = '{1'b0, BASE + 32'h04, 32'h0,         4'hF, 32'h0000_0000, 1'b1, "rd_status_rst"};
        vt[2]  = '{1'b0, BASE + 32'h10, 32'h0,         4'hF, 32'hFFFF_FFFF, 1'b1, "rd_oeblo0_rst"};
        vt[3]  = '{1'b0, BASE + 32'h14, 32'h0,         4'hF, 32'h0000_003F, 1'b1, "rd_oebhi0_rst"};
        vt[4]  = '{1'b1, BASE + 32'h20, 32'h0000_FF00, 4'hF, 32'h0000_0000, 1'b1, "wr_oeblo2"};
        vt[5]  = '{1'b0, BASE + 32'h20, 32'h0,         4'hF, 32'h0000_FF00, 1'b1, "rd_oeblo2"};
        vt[6]  = '{1'b1, BASE + 32'h24, 32'h0000_0015, 4'h1, 32'h0000_0000, 1'b1, "wr_oebhi2"};
        vt[7]  = '{1'b0, BASE + 32'h24, 32'h0,         4'hF, 32'h0000_0015, 1'b1, "rd_oebhi2"};
        vt[8]  = '{1'b1, BASE + 32'h28, 32'h1234_5678, 4'h5, 32'h0000_0000, 1'b1, "wr_oeblo3_sel5"};
        vt[9]  = '{1'b0, BASE + 32'h28, 32'h0,         4'hF, 32'hFF34_FF78, 1'b1, "rd_oeblo3_sel5"};
        vt[10] = '{1'b1, BASE + 32'h2C, 32'hFFFF_FF00, 4'hF, 32'h0000_0000, 1'b1, "wr_oebhi3"};
        vt[11] = '{1'b0, BASE + 32'h2C, 32'h0,         4'hF, 32'h0000_0000, 1'b1, "rd_oebhi3_unused"};
        vt[12] = '{1'b0, BASE + 32'hFC, 32'h0,         4'hF, 32'h0000_0000, 1'b1, "rd_unmapped_fc"};
        vt[13] = '{1'b1, BASE + 32'hF0, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b1, "wr_unmapped_f0"};
        vt[14] = '{1'b0, BASE + 32'hF0, 32'h0,         4'hF, 32'h0000_0000, 1'b1, "rd_unmapped_f0"};
        vt[15] = '{1'b0, BASE + 32'h50, 32'h0,         4'hF, 32'h0000_0000, 1'b1, "rd_oeblo8_none"};
        vt[16] = '{1'b0, BASE + 32'h100, 32'h0,        4'hF, 32'h0000_0000, 1'b0, "rd_above_window"};
        vt[17] = '{1'b0, BASE - 32'h4,  32'h0,         4'hF, 32'h0000_0000, 1'b0, "rd_below_window"};

        reset = 1'b1;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = '0;   wb.wbs_dat_i = '0;
        io_in = 38'h2A_5555_AAAA;
        for (int p = 0; p < N; p++) proj_io_out[p*IOP +: IOP] = pat(p);

        repeat (3) tick();
        chk("rst_proj_reset_high", 64'(proj_reset), 64'hFF);
        chk("rst_ack", 64'(wb.wbs_ack_o), 64'd0);
        chk("rst_dat", 64'(wb.wbs_dat_o), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_proj_reset", 64'(proj_reset), 64'd0);
        chk("post_rst_active", 64'(active_o), 64'd0);
        chk("post_rst_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        chk("post_rst_io_out", 64'(io_out), 64'(pat(0)));
        exp_pin = '0; exp_pin[IOP-1:0] = io_in;
        chk("post_rst_pin", 64'(proj_io_in[2*IOP-1:0]), 64'(exp_pin[2*IOP-1:0]));

        for (int i = 0; i < 18; i++) begin
            xfer(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, r, a);
            chk({vt[i].nm, "_ack"}, 64'(a), 64'(vt[i].exp_ack));
            chk(vt[i].nm, 64'(r), 64'(vt[i].exp));
        end

        // switch to slot 2; xfer returns one cycle after the ack, i.e. second guard cycle
        wr("sw2", 8'h00, 32'd2);
        for (int k = 1; k < G + R; k++) begin
            exp_pin = '0;
            if (k >= G) exp_pin[2*IOP +: IOP] = io_in;
            chk($sformatf("sw2_oeb_k%0d", k), 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
            chk($sformatf("sw2_out_k%0d", k), 64'(io_out), 64'd0);
            chk($sformatf("sw2_rst_k%0d", k), 64'(proj_reset), (k >= G) ? 64'h04 : 64'h00);
            chk($sformatf("sw2_pin_k%0d", k), 64'(proj_io_in[3*IOP-1:0] != exp_pin[3*IOP-1:0]), 64'd0);
            tick();
        end
        chk("sw2_oeb_idle", 64'(io_oeb), 64'({6'h15, 32'h0000_FF00}));
        chk("sw2_out_idle", 64'(io_out), 64'(pat(2)));
        chk("sw2_rst_idle", 64'(proj_reset), 64'd0);
        chk("sw2_active", 64'(active_o), 64'd2);
        exp_pin = '0; exp_pin[2*IOP +: IOP] = io_in;
        chk("sw2_pin_idle", 64'(proj_io_in != exp_pin), 64'd0);

        // ACTIVE writes while busy, then out of range
        wr("sw4", 8'h00, 32'd4);
        wr("busy_wr5", 8'h00, 32'd5);
        rd("rd_active_busy", 8'h00, 32'h0000_0104);
        rd("rd_status_busy_err", 8'h04, 32'h0000_0001);
        wait_idle();
        rd("rd_active_after_busy", 8'h00, 32'h0000_0004);
        wr("bad_wr9", 8'h00, 32'd9);
        rd("rd_status_both", 8'h04, 32'h0000_0003);
        rd("rd_active_after_bad", 8'h00, 32'h0000_0004);
        wr("clr_status", 8'h04, 32'h0);
        rd("rd_status_clr", 8'h04, 32'h0000_0000);

        // same slot: no sequence, no reset pulse
        wr("same4", 8'h00, 32'd4);
        any_rst = 0;
        repeat (6) begin
            if (proj_reset != '0 || io_oeb != pat(99) && 1'b0) any_rst++;
            tick();
        end
        chk("same4_no_reset", 64'(any_rst), 64'd0);
        rd("rd_active_same", 8'h00, 32'h0000_0004);

        // held strobe yields exactly one ack, data zero outside ack
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = BASE; wb.wbs_sel_i = 4'hF;
        n_ack = 0; bad_dat = 0;
        repeat (5) begin
            tick();
            if (wb.wbs_ack_o) n_ack++;
            else if (wb.wbs_dat_o != 32'd0) bad_dat++;
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        tick();
        chk("held_one_ack", 64'(n_ack), 64'd1);
        chk("held_dat_zero", 64'(bad_dat), 64'd0);

        // OEB write during a switch lands once idle
        wr("sw1", 8'h00, 32'd1);
        wr("oeb1_busy", 8'h18, 32'h0F0F_0F0F);
        chk("oeb1_busy_float", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        wait_idle();
        chk("oeb1_idle", 64'(io_oeb), 64'({6'h3F, 32'h0F0F_0F0F}));
        chk("sw1_out", 64'(io_out), 64'(pat(1)));
        exp_pin = '0; exp_pin[IOP +: IOP] = io_in;
        chk("sw1_pin", 64'(proj_io_in != exp_pin), 64'd0);

        // reset in the second guard cycle
        wr("sw3", 8'h00, 32'd3);
        reset = 1'b1;
        #1;
        chk("midrst_proj_reset", 64'(proj_reset), 64'hFF);
        tick();
        chk("midrst_active", 64'(active_o), 64'd0);
        chk("midrst_proj_reset2", 64'(proj_reset), 64'hFF);
        chk("midrst_oeb", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
        reset = 1'b0;
        tick();
        chk("midrst_out", 64'(io_out), 64'(pat(0)));
        chk("midrst_rst_low", 64'(proj_reset), 64'd0);
        rd("midrst_oeblo1", 8'h18, 32'hFFFF_FFFF);
        rd("midrst_oeblo2", 8'h20, 32'hFFFF_FFFF);
        rd("midrst_oebhi2", 8'h24, 32'h0000_003F);

        // completed-switch counter (reads 0 when the feature is absent)
        wr("cnt_sw1", 8'h00, 32'd1); wait_idle();
        wr("cnt_sw2", 8'h00, 32'd2); wait_idle();
        wr("cnt_sw3", 8'h00, 32'd3); wait_idle();
        wr("cnt_same3", 8'h00, 32'd3); wait_idle();
`ifdef SWITCH_COUNT_EN
        rd("switch_count", 8'h04, 32'h0003_0000);
`else
        rd("switch_count", 8'h04, 32'h0000_0000);
`endif
        rd("rd_active_final", 8'h00, 32'h0000_0003);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
